branch_resolve_predict: RTL and testbench

//  EX-stage branch resolution unit with a parametrised branch-history table (BHT) of 2-bit saturating counters.

---
 rtl/br_pkg.sv | 31 +++
 rtl/bht_table.sv | 35 +++
 rtl/branch_resolve_predict.sv | 117 +++++++++++
 tb/tb_branch_resolve_predict.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and helpers for the branch resolution / prediction unit.
package br_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [3:0] ALU_ADD    = 4'd0;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'd0,
        F3_BNE  = 3'd1,
        F3_BLT  = 3'd4,
        F3_BGE  = 3'd5,
        F3_BLTU = 3'd6,
        F3_BGEU = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    function automatic bht_state_t sat_inc(input bht_state_t s);
        return (s == ST) ? ST : bht_state_t'(s + 2'd1);
    endfunction

    function automatic bht_state_t sat_dec(input bht_state_t s);
        return (s == SNT) ? SNT : bht_state_t'(s - 2'd1);
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch-history table of 2-bit saturating counters: async read for IF,
// read-modify-write training port for EX, synchronous reset to weakly not-taken.
module bht_table
    import br_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_state_t       rd_state,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_state_t mem [DEPTH];
    bht_state_t upd_cur;

    // IF read sees the stored value only; a same-cycle update is not bypassed.
    assign rd_state = mem[rd_idx];
    assign upd_cur  = mem[upd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WNT;
            end
        end else if (upd_en) begin
            mem[upd_idx] <= upd_taken ? sat_inc(upd_cur) : sat_dec(upd_cur);
        end
    end

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolution with BHT prediction for IF.
// Optional performance counters enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_predict
    import br_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic             br_eq,
    input  logic             br_lt,
    output logic             br_un,
    input  logic             a_sel_i,
    input  logic             b_sel_i,
    input  logic             pc_sel_i,
    input  logic [3:0]       alu_sel_i,
    output logic             a_sel_o,
    output logic             b_sel_o,
    output logic             pc_sel_o,
    output logic [3:0]       alu_sel_o,
    output logic             redirect,
    output logic             redirect_src,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic       is_br;
    logic       taken;
    logic       f3_taken;
    logic       f3_illegal;
    logic       bht_upd;
    bht_state_t if_state;
    logic       unused_pc_bits;

    assign is_br = ex_valid && (ex_opcode == OPC_BRANCH);

    always_comb begin
        f3_taken   = 1'b0;
        f3_illegal = 1'b0;
        case (ex_funct3)
            F3_BEQ:           f3_taken = br_eq;
            F3_BNE:           f3_taken = ~br_eq;
            F3_BLT, F3_BLTU:  f3_taken = br_lt;
            F3_BGE, F3_BGEU:  f3_taken = ~br_lt;
            default:          f3_illegal = 1'b1;
        endcase
    end

    assign taken        = is_br & f3_taken;
    assign illegal_br   = is_br & f3_illegal;
    assign br_un        = is_br & ex_funct3[1];
    assign redirect     = is_br & (taken != ex_pred_taken);
    assign redirect_src = ~taken;

    // Taken branches compute PC+imm in the ALU; not-taken ones fall through.
    always_comb begin
        a_sel_o   = a_sel_i;
        b_sel_o   = b_sel_i;
        pc_sel_o  = pc_sel_i;
        alu_sel_o = alu_sel_i;
        if (is_br) begin
            a_sel_o   = taken;
            b_sel_o   = taken;
            pc_sel_o  = taken;
            alu_sel_o = ALU_ADD;
        end
    end

    assign bht_upd = is_br & ~ex_stall;

    bht_table #(.DEPTH(BHT_DEPTH)) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_state  (if_state),
        .upd_en    (bht_upd),
        .upd_idx   (ex_pc[IDX_W+1:2]),
        .upd_taken (taken)
    );

    assign if_pred_taken  = if_state[1];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (bht_upd) begin
            if (br_count != '1) begin
                br_count <= br_count + 1'b1;
            end
            if (redirect && (mispred_count != '1)) begin
                mispred_count <= mispred_count + 1'b1;
            end
        end
    end
`else
    assign br_count      = '0;
    assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Self-checking bench for branch_resolve_predict: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_branch_resolve_predict;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_stall;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic             br_eq;
    logic             br_lt;
    logic             br_un;
    logic             a_sel_i, b_sel_i, pc_sel_i;
    logic [3:0]       alu_sel_i;
    logic             a_sel_o, b_sel_o, pc_sel_o;
    logic [3:0]       alu_sel_o;
    logic             redirect;
    logic             redirect_src;
    logic             illegal_br;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    branch_resolve_predict #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .br_eq(br_eq), .br_lt(br_lt), .br_un(br_un),
        .a_sel_i(a_sel_i), .b_sel_i(b_sel_i), .pc_sel_i(pc_sel_i), .alu_sel_i(alu_sel_i),
        .a_sel_o(a_sel_o), .b_sel_o(b_sel_o), .pc_sel_o(pc_sel_o), .alu_sel_o(alu_sel_o),
        .redirect(redirect), .redirect_src(redirect_src), .illegal_br(illegal_br),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: one small integer per BHT entry, plain counts.
    int     bht_m [DEPTH];
    longint br_m;
    longint mis_m;

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit rule_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit m_is_br();
        return ex_valid && (ex_opcode == 7'h63);
    endfunction

    function automatic logic [31:0] exp_cnt(input longint v);
`ifdef BRU_PERF_CNT_EN
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic check_model();
        bit br, tk, ill;
        br  = m_is_br();
        tk  = br && rule_taken(ex_funct3, br_eq, br_lt);
        ill = br && (ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
        chk("m_a_sel",    a_sel_o,   br ? tk : a_sel_i);
        chk("m_b_sel",    b_sel_o,   br ? tk : b_sel_i);
        chk("m_pc_sel",   pc_sel_o,  br ? tk : pc_sel_i);
        chk("m_alu_sel",  alu_sel_o, br ? 4'd0 : alu_sel_i);
        chk("m_redirect", redirect,  br && (tk != ex_pred_taken));
        chk("m_rsrc",     redirect_src, !tk);
        chk("m_illegal",  illegal_br, ill);
        chk("m_br_un",    br_un,     br && ex_funct3[1]);
        chk("m_pred",     if_pred_taken, bht_m[idx_of(if_pc)] >= 2);
        chk("m_br_count", br_count,  exp_cnt(br_m));
        chk("m_mis_count", mispred_count, exp_cnt(mis_m));
    endtask

    // Advance one clock, applying the model's view of the same edge.
    task automatic tick();
        bit br, tk;
        @(posedge clk);
        br = m_is_br();
        tk = br && rule_taken(ex_funct3, br_eq, br_lt);
        if (!rst_n) begin
            foreach (bht_m[i]) bht_m[i] = 1;
            br_m  = 0;
            mis_m = 0;
        end else if (br && !ex_stall) begin
            int k;
            k = idx_of(ex_pc);
            bht_m[k] = tk ? ((bht_m[k] == 3) ? 3 : bht_m[k] + 1)
                          : ((bht_m[k] == 0) ? 0 : bht_m[k] - 1);
            br_m++;
            if (tk != ex_pred_taken) mis_m++;
        end
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_opcode = 7'h13; ex_funct3 = 3'd0;
        ex_pc = '0; ex_pred_taken = 1'b0; br_eq = 1'b0; br_lt = 1'b0;
        a_sel_i = 1'b0; b_sel_i = 1'b0; pc_sel_i = 1'b0; alu_sel_i = 4'd0;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [XLEN-1:0] pc,
                          input logic eq, input logic lt, input logic pred);
        ex_valid = 1'b1; ex_stall = 1'b0; ex_opcode = 7'h63; ex_funct3 = f3;
        ex_pc = pc; br_eq = eq; br_lt = lt; ex_pred_taken = pred;
    endtask

    typedef struct {
        logic       valid;
        logic [6:0] op;
        logic [2:0] f3;
        logic       eq, lt, pred;
        logic       a_i, b_i, pc_i;
        logic [3:0] alu_i;
        logic       a_o, b_o, pc_o;
        logic [3:0] alu_o;
        logic       redir, src, ill, un;
    } vec_t;

    vec_t tbl [$];

    initial begin
        //          v  op     f3  eq lt pr  ai bi pi alu    ao bo po alu   rd sr il un
        tbl.push_back('{1, 7'h63, 3'd0, 1, 0, 0, 0, 0, 0, 4'd5, 1, 1, 1, 4'd0, 1, 0, 0, 0});
        tbl.push_back('{1, 7'h63, 3'd0, 0, 0, 0, 1, 1, 1, 4'd5, 0, 0, 0, 4'd0, 0, 1, 0, 0});
        tbl.push_back('{1, 7'h63, 3'd1, 0, 1, 1, 0, 0, 0, 4'd7, 1, 1, 1, 4'd0, 0, 0, 0, 0});
        tbl.push_back('{1, 7'h63, 3'd4, 0, 1, 0, 0, 0, 0, 4'd2, 1, 1, 1, 4'd0, 1, 0, 0, 0});
        tbl.push_back('{1, 7'h63, 3'd5, 1, 1, 1, 1, 0, 1, 4'd9, 0, 0, 0, 4'd0, 1, 1, 0, 0});
        tbl.push_back('{1, 7'h63, 3'd6, 0, 1, 1, 0, 0, 0, 4'd1, 1, 1, 1, 4'd0, 0, 0, 0, 1});
        tbl.push_back('{1, 7'h63, 3'd7, 1, 0, 0, 0, 0, 0, 4'd1, 1, 1, 1, 4'd0, 1, 0, 0, 1});
        tbl.push_back('{1, 7'h63, 3'd2, 1, 1, 0, 1, 1, 1, 4'd3, 0, 0, 0, 4'd0, 0, 1, 1, 1});
        tbl.push_back('{1, 7'h63, 3'd3, 0, 0, 1, 0, 0, 0, 4'd3, 0, 0, 0, 4'd0, 1, 1, 1, 1});
        tbl.push_back('{1, 7'h33, 3'd0, 1, 0, 1, 0, 1, 1, 4'd5, 0, 1, 1, 4'd5, 0, 1, 0, 0});
        tbl.push_back('{0, 7'h63, 3'd0, 1, 0, 0, 1, 0, 0, 4'd3, 1, 0, 0, 4'd3, 0, 1, 0, 0});
        tbl.push_back('{0, 7'h63, 3'd6, 0, 1, 1, 0, 1, 0, 4'd4, 0, 1, 0, 4'd4, 0, 1, 0, 0});
    end

    initial begin
        foreach (bht_m[i]) bht_m[i] = 1;
        br_m = 0;
        mis_m = 0;
        idle();
        rst_n = 1'b0;
        if_pc = 32'h100;
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Reset state: every entry weakly not-taken, counters cleared
        chk("rst_pred_0x100", if_pred_taken, 1'b0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_mis_count", mispred_count, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if_pc = 32'(i * 4);
            #1;
            chk("rst_pred_idx", if_pred_taken, 1'b0);
        end

        // Combinational vector table, stalled so the BHT is left alone
        foreach (tbl[i]) begin
            ex_valid = tbl[i].valid; ex_stall = 1'b1; ex_opcode = tbl[i].op;
            ex_funct3 = tbl[i].f3; ex_pc = 32'h400; br_eq = tbl[i].eq; br_lt = tbl[i].lt;
            ex_pred_taken = tbl[i].pred; a_sel_i = tbl[i].a_i; b_sel_i = tbl[i].b_i;
            pc_sel_i = tbl[i].pc_i; alu_sel_i = tbl[i].alu_i;
            #1;
            chk("vec_a_sel", a_sel_o, tbl[i].a_o);
            chk("vec_b_sel", b_sel_o, tbl[i].b_o);
            chk("vec_pc_sel", pc_sel_o, tbl[i].pc_o);
            chk("vec_alu_sel", alu_sel_o, tbl[i].alu_o);
            chk("vec_redirect", redirect, tbl[i].redir);
            chk("vec_rsrc", redirect_src, tbl[i].src);
            chk("vec_illegal", illegal_br, tbl[i].ill);
            chk("vec_br_un", br_un, tbl[i].un);
        end
        tick();
        if_pc = 32'h400;
        #1;
        chk("stalled_entry_unchanged", if_pred_taken, 1'b0);
        chk("stalled_br_count", br_count, 32'd0);
        idle();

        // BEQ taken, mispredicted; same-cycle read sees the old entry
        set_br(3'd0, 32'h100, 1'b1, 1'b0, 1'b0);
        if_pc = 32'h100;
        #1;
        chk("beq_pc_sel", pc_sel_o, 1'b1);
        chk("beq_redirect", redirect, 1'b1);
        chk("beq_rsrc", redirect_src, 1'b0);
        chk("beq_no_bypass", if_pred_taken, 1'b0);
        tick();
        idle();
        #1;
        chk("beq_entry_wt", if_pred_taken, 1'b1);

        // BGEU taken, predicted; four repeats saturate at ST
        if_pc = 32'h200;
        for (int r = 0; r < 4; r++) begin
            set_br(3'd7, 32'h200, 1'b0, 1'b0, 1'b1);
            #1;
            chk("bgeu_br_un", br_un, 1'b1);
            chk("bgeu_redirect", redirect, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("bgeu_pred", if_pred_taken, 1'b1);

        // BNE not taken, mispredicted
        set_br(3'd1, 32'h104, 1'b1, 1'b0, 1'b1);
        #1;
        chk("bne_pc_sel", pc_sel_o, 1'b0);
        chk("bne_redirect", redirect, 1'b1);
        chk("bne_rsrc", redirect_src, 1'b1);
        tick();
        idle();
        #1;
`ifdef BRU_PERF_CNT_EN
        chk("perf_br_count", br_count, 32'd6);
        chk("perf_mis_count", mispred_count, 32'd2);
`else
        chk("noperf_br_count", br_count, 32'd0);
        chk("noperf_mis_count", mispred_count, 32'd0);
`endif

        // 0x200 held at ST: two decrements needed before it predicts not-taken
        set_br(3'd0, 32'h200, 1'b0, 1'b0, 1'b1);
        tick();
        chk("st_to_wt_pred", if_pred_taken, 1'b1);
        tick();
        chk("wt_to_wnt_pred", if_pred_taken, 1'b0);

        // 0x104 now SNT: two increments needed before it predicts taken
        if_pc = 32'h104;
        set_br(3'd0, 32'h104, 1'b1, 1'b0, 1'b0);
        tick();
        chk("snt_to_wnt_pred", if_pred_taken, 1'b0);
        tick();
        chk("wnt_to_wt_pred", if_pred_taken, 1'b1);

        // Stall: resolves but does not train
        if_pc = 32'h300;
        set_br(3'd0, 32'h300, 1'b1, 1'b0, 1'b0);
        ex_stall = 1'b1;
        #1;
        chk("stall_pc_sel", pc_sel_o, 1'b1);
        chk("stall_redirect", redirect, 1'b1);
        tick();
        tick();
        chk("stall_no_train", if_pred_taken, 1'b0);
        check_model();

        // Reset during a training cycle drops the update and clears the table
        if_pc = 32'h100;
        set_br(3'd0, 32'h100, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_comb_follows", pc_sel_o, 1'b1);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk("rst_mid_pred", if_pred_taken, 1'b0);
        chk("rst_mid_br_count", br_count, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst_n         = ($urandom_range(0, 79) != 0);
            ex_valid      = ($urandom_range(0, 9) != 0);
            ex_stall      = ($urandom_range(0, 5) == 0);
            ex_opcode     = ($urandom_range(0, 3) != 0) ? 7'h63 : 7'($urandom);
            ex_funct3     = 3'($urandom);
            ex_pc         = {22'($urandom), 3'($urandom_range(0, 7)), 5'($urandom), 2'b00};
            ex_pred_taken = 1'($urandom);
            br_eq         = 1'($urandom);
            br_lt         = 1'($urandom);
            a_sel_i       = 1'($urandom);
            b_sel_i       = 1'($urandom);
            pc_sel_i      = 1'($urandom);
            alu_sel_i     = 4'($urandom);
            if_pc         = ($urandom_range(0, 1) != 0) ? ex_pc : 32'($urandom);
            #1;
            check_model();
            tick();
        end
        rst_n = 1'b1;
        idle();
        #1;
        check_model();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
